// File: rtl/rt_tile_scheduler_if.sv
// Beat stream from the tile scheduler to the ray-generation unit.
// The master drives the pixel/sample payload; the slave returns out_ready.
interface rt_tile_scheduler_if #(
    parameter int COORD_W = 16,
    parameter int SPP_W   = 4
);
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SPP_W-1:0]   sample;
    logic               out_last;

    modport master (output out_valid, x, y, sample, out_last, input out_ready);
    modport slave  (input out_valid, x, y, sample, out_last, output out_ready);
endinterface

// File: rtl/rt_tile_scheduler.sv
// Walks a programmable-size image in raster or tiled order, emitting each pixel
// spp times, then waits PIPE_DEPTH advancing pipeline cycles before pulsing done.
module rt_tile_scheduler #(
    parameter int COORD_W    = 16,
    parameter int TILE_W     = 8,
    parameter int TILE_H     = 8,
    parameter int SPP_W      = 4,
    parameter int PIPE_DEPTH = 5
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    input  logic [COORD_W-1:0]  image_width,
    input  logic [COORD_W-1:0]  image_height,
    input  logic [SPP_W-1:0]    spp,
    input  logic                tile_mode,
    input  logic                pipe_en,
    rt_tile_scheduler_if.master beat_if,
    output logic                busy,
    output logic                done
);
    localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [COORD_W-1:0] X_MASK = COORD_W'(TILE_W - 1);
    localparam logic [COORD_W-1:0] Y_MASK = COORD_W'(TILE_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state, w_state_nxt;
    logic [COORD_W-1:0] r_w, r_h, r_x, r_y;
    logic [SPP_W-1:0]   r_spp, r_sample;
    logic               r_tile, r_valid, r_last, r_done;
    logic [DRAIN_W-1:0] r_drain;

    logic [COORD_W-1:0] w_x_nxt, w_y_nxt;
    logic [SPP_W-1:0]   w_s_nxt, w_spp_in;
    logic               w_zero, w_xfer, w_drain_done, w_start_ok;
    logic               w_s_end, w_x_end, w_y_end, w_x_tile_end, w_y_tile_end;
    logic               w_last_nxt, w_valid_nxt, w_done_nxt, w_first, w_adv;

    assign w_spp_in     = (spp == '0) ? SPP_W'(1) : spp;
    assign w_zero       = (image_width == '0) || (image_height == '0);
    assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
    assign w_xfer       = r_valid && beat_if.out_ready;
    assign w_drain_done = (r_state == S_DRAIN) && pipe_en &&
                          (r_drain == DRAIN_W'(PIPE_DEPTH - 1));

    // Tile boundaries fall on multiples of TILE_W/TILE_H, so the low coordinate
    // bits locate the tile edge; the image edge clips the last tile.
    assign w_s_end      = (r_sample == r_spp - SPP_W'(1));
    assign w_x_end      = (r_x == r_w - COORD_W'(1));
    assign w_y_end      = (r_y == r_h - COORD_W'(1));
    assign w_x_tile_end = w_x_end || ((r_x & X_MASK) == X_MASK);
    assign w_y_tile_end = w_y_end || ((r_y & Y_MASK) == Y_MASK);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start && !w_zero) w_state_nxt = S_RUN;
                S_RUN:   if (w_xfer && r_last) w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_drain_done)     w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode: what the registered outputs become on the next edge.
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_first     = 1'b0;
        w_adv       = 1'b0;
        if (abort) begin
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_zero) w_done_nxt = 1'b1;
                    if (start && !w_zero) begin
                        w_valid_nxt = 1'b1;
                        w_first     = 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_xfer && r_last)  w_valid_nxt = 1'b0;
                    if (w_xfer && !r_last) w_adv = 1'b1;
                end
                S_DRAIN: w_done_nxt = w_drain_done;
                default: w_valid_nxt = 1'b0;
            endcase
        end
    end

    // Traversal step: sample, then x/y in raster or tile-major order.
    always_comb begin
        w_s_nxt = r_sample + SPP_W'(1);
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_s_end) begin
            w_s_nxt = '0;
            if (!r_tile) begin
                w_x_nxt = w_x_end ? '0 : r_x + COORD_W'(1);
                w_y_nxt = w_x_end ? r_y + COORD_W'(1) : r_y;
            end else if (!w_x_tile_end) begin
                w_x_nxt = r_x + COORD_W'(1);
            end else if (!w_y_tile_end) begin
                w_x_nxt = r_x & ~X_MASK;
                w_y_nxt = r_y + COORD_W'(1);
            end else if (!w_x_end) begin
                w_x_nxt = r_x + COORD_W'(1);
                w_y_nxt = r_y & ~Y_MASK;
            end else begin
                w_x_nxt = '0;
                w_y_nxt = r_y + COORD_W'(1);
            end
        end
        w_last_nxt = (w_x_nxt == r_w - COORD_W'(1)) && (w_y_nxt == r_h - COORD_W'(1)) &&
                     (w_s_nxt == r_spp - SPP_W'(1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_w      <= '0;
            r_h      <= '0;
            r_spp    <= '0;
            r_tile   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_drain  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            if (w_start_ok) begin
                r_w    <= image_width;
                r_h    <= image_height;
                r_spp  <= w_spp_in;
                r_tile <= tile_mode;
            end
            if (abort || w_first) begin
                r_x      <= '0;
                r_y      <= '0;
                r_sample <= '0;
                r_last   <= !abort && (image_width == COORD_W'(1)) &&
                            (image_height == COORD_W'(1)) && (w_spp_in == SPP_W'(1));
            end else if (w_adv) begin
                r_x      <= w_x_nxt;
                r_y      <= w_y_nxt;
                r_sample <= w_s_nxt;
                r_last   <= w_last_nxt;
            end else if (w_xfer) begin
                r_last <= 1'b0;
            end
            if (r_state != S_DRAIN) r_drain <= '0;
            else if (pipe_en)       r_drain <= r_drain + DRAIN_W'(1);
        end
    end

    assign beat_if.out_valid = r_valid;
    assign beat_if.x         = r_x;
    assign beat_if.y         = r_y;
    assign beat_if.sample    = r_sample;
    assign beat_if.out_last  = r_last;
    assign busy              = (r_state != S_IDLE);
    assign done              = r_done;
endmodule

// File: tb/tb_rt_tile_scheduler.sv
// Randomized bench for rt_tile_scheduler: each frame is compared beat by beat
// against an order list built from nested loops over pixels, tiles and samples.
module tb_rt_tile_scheduler;
    localparam int CW = 16;
    localparam int SW = 4;
    localparam int TW = 8;
    localparam int TH = 8;
    localparam int PD = 5;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [SW-1:0] s;
    } beat_t;

    logic          clk, resetn, start, abort, tile_mode, pipe_en, busy, done;
    logic [CW-1:0] image_width, image_height;
    logic [SW-1:0] spp;
    int            total, bad;
    beat_t         exp_q[$];

    rt_tile_scheduler_if #(.COORD_W(CW), .SPP_W(SW)) bif ();

    rt_tile_scheduler #(
        .COORD_W(CW), .TILE_W(TW), .TILE_H(TH), .SPP_W(SW), .PIPE_DEPTH(PD)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .image_width(image_width), .image_height(image_height), .spp(spp),
        .tile_mode(tile_mode), .pipe_en(pipe_en), .beat_if(bif.master),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference order: rows of pixels, or tiles (row-major) of clipped pixel rows.
    task automatic build_expected(input int w, input int h, input int sp, input bit tile);
        int se;
        beat_t b;
        se = (sp == 0) ? 1 : sp;
        exp_q.delete();
        for (int ty = 0; ty < h; ty += (tile ? TH : h))
            for (int tx = 0; tx < w; tx += (tile ? TW : w))
                for (int yy = ty; yy < ((tile && ty + TH < h) ? ty + TH : h); yy++)
                    for (int xx = tx; xx < ((tile && tx + TW < w) ? tx + TW : w); xx++)
                        for (int s = 0; s < se; s++) begin
                            b.x = CW'(xx);
                            b.y = CW'(yy);
                            b.s = SW'(s);
                            exp_q.push_back(b);
                        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after start is sampled.
    task automatic start_frame(input int w, input int h, input int sp, input bit tile);
        image_width  = CW'(w);
        image_height = CW'(h);
        spp          = SW'(sp);
        tile_mode    = tile;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        image_width  = CW'($urandom);
        image_height = CW'($urandom);
        spp          = SW'($urandom);
        tile_mode    = 1'($urandom);
    endtask

    // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random.
    // pmode: 0 pipe_en always, 1 low for the first 3 drain cycles, 2 random.
    task automatic run_frame(input int w, input int h, input int sp, input bit tile,
                             input int rmode, input int pmode, input string tag);
        int idx, cyc, n, pcnt, dcyc, limit;
        logic rdy, pe;
        logic [39:0] obs, want;
        build_expected(w, h, sp, tile);
        n = exp_q.size();
        idx = 0; cyc = 0; pcnt = 0; dcyc = 0;
        limit = 4 * n + 100;
        while (idx < n) begin
            obs  = {bif.out_valid, bif.x, bif.y, bif.sample, bif.out_last, busy, done};
            want = {1'b1, exp_q[idx].x, exp_q[idx].y, exp_q[idx].s, (idx == n - 1), 1'b1, 1'b0};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL %s beat %0d: got v=%0b x=%0d y=%0d s=%0d last=%0b busy=%0b done=%0b, want v=1 x=%0d y=%0d s=%0d last=%0b busy=1 done=0",
                         tag, idx, obs[39], obs[38:23], obs[22:7], obs[6:3], obs[2], obs[1], obs[0],
                         exp_q[idx].x, exp_q[idx].y, exp_q[idx].s, (idx == n - 1));
            end
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom);
            bif.out_ready = rdy;
            pipe_en = 1'($urandom);
            @(negedge clk);
            cyc++;
            if (rdy) idx++;
            if (cyc > limit) begin
                total++; bad++;
                $display("FAIL %s run timeout: got %0d beats, want %0d", tag, idx, n);
                return;
            end
        end
        forever begin
            total++;
            if ({bif.out_valid, bif.out_last, busy, done} !== 4'b0010) begin
                bad++;
                $display("FAIL %s drain cycle %0d: got v/last/busy/done=%b, want 0010",
                         tag, dcyc, {bif.out_valid, bif.out_last, busy, done});
            end
            pe = (pmode == 0) ? 1'b1 : (pmode == 1) ? (dcyc >= 3) : 1'($urandom);
            pipe_en = pe;
            bif.out_ready = 1'($urandom);
            if (pe) pcnt++;
            @(negedge clk);
            dcyc++;
            if (pcnt == PD) break;
            if (dcyc > 1000) begin
                total++; bad++;
                $display("FAIL %s drain timeout", tag);
                return;
            end
        end
        total++;
        if ({bif.out_valid, busy, done} !== 3'b001) begin
            bad++;
            $display("FAIL %s done: got v/busy/done=%b, want 001 after %0d drain cycles",
                     tag, {bif.out_valid, busy, done}, dcyc);
        end
        pipe_en = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b1; start = 1'b0; abort = 1'b0; pipe_en = 1'b1; tile_mode = 1'b0;
        image_width = '0; image_height = '0; spp = '0; bif.out_ready = 1'b0;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bif.out_valid, bif.x, bif.y, bif.sample, bif.out_last, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset state: got v=%0b x=%0d y=%0d s=%0d last=%0b busy=%0b done=%0b, want all 0",
                     bif.out_valid, bif.x, bif.y, bif.sample, bif.out_last, busy, done);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_raster();
        start_frame(4, 2, 1, 1'b0);
        run_frame(4, 2, 1, 1'b0, 0, 0, "raster");
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        start_frame(3, 1, 2, 1'b0);
        run_frame(3, 1, 2, 1'b0, 1, 1, "backpressure");
        @(negedge clk);
    endtask

    task automatic test_tiled();
        start_frame(10, 10, 1, 1'b1);
        run_frame(10, 10, 1, 1'b1, 0, 0, "tiled");
        @(negedge clk);
    endtask

    task automatic test_spp_zero();
        start_frame(1, 1, 0, 1'b0);
        run_frame(1, 1, 0, 1'b0, 0, 0, "spp_zero");
        @(negedge clk);
    endtask

    task automatic test_zero_size();
        for (int k = 0; k < 2; k++) begin
            start_frame(k == 0 ? 0 : 5, k == 0 ? 5 : 0, 1, 1'b0);
            total++;
            if ({bif.out_valid, busy, done} !== 3'b001) begin
                bad++;
                $display("FAIL zero_size %0d pulse: got v/busy/done=%b, want 001", k, {bif.out_valid, busy, done});
            end
            repeat (3) begin
                @(negedge clk);
                total++;
                if ({bif.out_valid, busy, done} !== 3'b000) begin
                    bad++;
                    $display("FAIL zero_size %0d after: got v/busy/done=%b, want 000", k, {bif.out_valid, busy, done});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        start_frame(5, 3, 2, 1'b1);
        run_frame(5, 3, 2, 1'b1, 2, 0, "b2b_first");
        start_frame(2, 2, 1, 1'b0);
        run_frame(2, 2, 1, 1'b0, 0, 2, "b2b_second");
        @(negedge clk);
    endtask

    task automatic test_abort();
        start_frame(4, 4, 1, 1'b0);
        bif.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bif.out_valid, bif.x, bif.y} !== {1'b1, CW'(3), CW'(0)}) begin
            bad++;
            $display("FAIL abort pre: got v=%0b x=%0d y=%0d, want v=1 x=3 y=0", bif.out_valid, bif.x, bif.y);
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        repeat (4) begin
            total++;
            if ({bif.out_valid, bif.out_last, busy, done} !== 4'b0000) begin
                bad++;
                $display("FAIL abort after: got v/last/busy/done=%b, want 0000",
                         {bif.out_valid, bif.out_last, busy, done});
            end
            @(negedge clk);
        end
        start_frame(4, 4, 1, 1'b0);
        run_frame(4, 4, 1, 1'b0, 0, 0, "abort_restart");
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        start_frame(6, 6, 2, 1'b1);
        bif.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({bif.out_valid, bif.x, bif.y, bif.sample, bif.out_last, busy, done} !== '0) begin
            bad++;
            $display("FAIL async_reset: got v=%0b x=%0d y=%0d s=%0d last=%0b busy=%0b done=%0b, want all 0",
                     bif.out_valid, bif.x, bif.y, bif.sample, bif.out_last, busy, done);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int w, h, sp;
            bit tl;
            w  = $urandom_range(1, 20);
            h  = $urandom_range(1, 20);
            sp = $urandom_range(0, 3);
            tl = 1'($urandom);
            start_frame(w, h, sp, tl);
            run_frame(w, h, sp, tl, 2, 2, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_raster();
        test_backpressure();
        test_tiled();
        test_spp_zero();
        test_zero_size();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rt_tile_scheduler.md
Name: rt_tile_scheduler

Overview:
Generates the pixel/sample work stream that feeds the ray-generation unit (RGU). It traverses an image of runtime-programmable size in either raster or tiled order, emitting each pixel one or more times (samples per pixel) over a valid/ready handshake. After the final beat it waits for the downstream pipeline to drain, then signals completion. It sits between the host/control registers and the RGU.

Parameters:
COORD_W, 16, width of x, y, image_width, image_height
TILE_W, 8, tile width in pixels for tiled mode; power of two, >=1
TILE_H, 8, tile height in pixels for tiled mode; power of two, >=1
SPP_W, 4, width of the samples-per-pixel field and the sample index
PIPE_DEPTH, 5, downstream pipeline depth to drain after the last beat; >=1

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  begin a frame; sampled only in IDLE
abort  in  1  cancel the frame from any state
image_width  in  COORD_W  frame width in pixels; latched on accepted start
image_height  in  COORD_W  frame height in pixels; latched on accepted start
spp  in  SPP_W  samples per pixel, latched on start; 0 is treated as 1
tile_mode  in  1  0 = raster order, 1 = tiled order; latched on start
pipe_en  in  1  downstream pipeline advanced this cycle (not stalled)
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
x  out  COORD_W  pixel x of current beat
y  out  COORD_W  pixel y of current beat
sample  out  SPP_W  sample index of current beat, 0..spp-1
out_last  out  1  current beat is the final beat of the frame
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset is asynchronous and active-low. While resetn=0: state=IDLE; out_valid, out_last, busy, done, x, y, sample and all counters are 0.
- States: IDLE, RUN, DRAIN. All outputs are registered.
- IDLE: when start=1 and abort=0, latch image_width, image_height, spp (0 becomes 1) and tile_mode.
  - If either latched dimension is 0, pulse done on the next cycle and stay in IDLE.
  - Otherwise go to RUN. On the next cycle out_valid=1 and x=y=sample=0.
- start is ignored outside IDLE. Input changes after an accepted start have no effect until the next frame.
- Transfer occurs when out_valid && out_ready. While out_valid=1 and out_ready=0, x, y, sample and out_last hold stable.
- Advance order after each transfer, innermost first:
  - sample: 0..spp-1.
  - Raster mode: then x: 0..W-1; then y: 0..H-1.
  - Tiled mode: then x within the tile; then y within the tile; then tile column; then tile row.
  - Tile origins are at multiples of TILE_W/TILE_H. Edge tiles are clipped to W/H; no out-of-image coordinate is ever emitted.
- Back-to-back: with out_ready held high, one beat transfers per cycle with no bubbles. Frame length is exactly W*H*spp beats.
- out_last=1 only on the beat with x=W-1, y=H-1, sample=spp-1 (this is the last beat in both modes).
- When the out_last beat transfers: out_valid=0 next cycle and the state goes to DRAIN.
- DRAIN: the drain counter clears on entry and increments on each pipe_en=1 cycle. On the PIPE_DEPTH-th pipe_en cycle:
  - done pulses for one cycle on the following cycle;
  - the state goes to IDLE.
- A new start is accepted in the same cycle done is high.
- busy = (state != IDLE).
- abort=1 in any state forces IDLE on the next cycle: out_valid=0, out_last=0, no done pulse. abort has priority over start and over transfer.
- Counter arithmetic is unsigned at COORD_W. The W-1/H-1 comparisons use the latched values; W=2^COORD_W-1 must traverse correctly.

Test Plan:
- Raster frame: W=4, H=2, spp=1, out_ready=1, pipe_en=1 -> 8 consecutive beats (0,0)..(3,0),(0,1)..(3,1); out_last only on (3,1); done pulses 5 cycles after the last transfer; busy falls with done.
- Backpressure: W=3, H=1, spp=2, out_ready toggling 1,0,0,1... -> beats (0,0,s0),(0,0,s1),(1,0,s0)..(2,0,s1), payload stable while stalled, exactly 6 transfers; pipe_en low for 3 DRAIN cycles delays done by 3.
- Tiled frame: TILE 8x8 at defaults, W=10, H=10, tile_mode=1 -> order is x0..7,y0..7 (64 beats), then x8..9,y0..7 (16), then x0..7,y8..9 (16), then x8..9,y8..9 (4); total 100; out_last on (9,9).
- spp=0 with W=H=1 -> single beat, sample=0, out_last=1, then done.
- Zero size: W=0, H=5, start -> done pulses the next cycle, out_valid never rises, busy stays 0.
- Abort and reset: abort asserted after 3 beats of a 4x4 frame -> out_valid=0 next cycle, no done, a new start restarts at (0,0); resetn asserted asynchronously mid-RUN -> all outputs 0 immediately.
